sdram_cmd_sequencer: RTL and testbench
======================================

Name: sdram_cmd_sequencer

Overview:
- Consumes the decoded command strobes from the SDRAM control-interface stage (NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE, SADDR, REF_REQ, INIT_REQ).
- Issues timed SDRAM pin commands and returns the REF_ACK and CM_ACK handshakes to that stage.
- Single-bank-at-a-time, auto-precharge burst engine; it also executes the init sequence (precharge-all, refreshes, mode load).

Parameters:
- COL_W, 8, column address bits
- ROW_W, 12, row address bits
- BANK_W, 2, bank bits; ASIZE = BANK_W+ROW_W+COL_W, SADDR = {bank,row,col}
- BURST, 8, burst length in beats (1..8)
- CL, 3, CAS latency (2 or 3)
- T_RCD, 3, ACTIVE-to-column cycles
- T_RP, 3, precharge cycles
- T_WR, 2, write recovery cycles
- T_RFC, 7, refresh cycle time
- T_MRD, 2, mode-load cycles
- MODE_REG, 12'h033, value driven on SA during LOAD MODE

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- NOP, READA, WRITEA  in  1 each  decoded commands (levels)
- REFRESH, PRECHARGE, LOAD_MODE  in  1 each  init pulses (1 cycle)
- SADDR  in  ASIZE  registered address
- REF_REQ  in  1  hidden refresh request (level)
- INIT_REQ  in  1  init in progress
- REF_ACK  out  1  refresh accepted pulse
- CM_ACK  out  1  read/write accepted pulse
- SA  out  ROW_W  SDRAM address
- BA  out  BANK_W  bank
- CS_N, RAS_N, CAS_N, WE_N  out  1 each  command pins
- CKE  out  1  clock enable
- OE  out  1  write-data drive enable
- RD_VALID  out  1  read data valid on DQ
- BUSY  out  1  sequencer not in IDLE

Behaviour:
- Clock and reset: one clock domain, CLK. RESET is synchronous and active-high.
- Reset values: CS_N/RAS_N/CAS_N/WE_N=1 (deselect), SA=0, BA=0, CKE=1, OE=0, RD_VALID=0, REF_ACK=0, CM_ACK=0, BUSY=0.
  - Reset also clears the pending flags and wait counters and forces IDLE.
  - Reset mid-burst aborts with no further pin commands.
- Pin encodings, {CS_N,RAS_N,CAS_N,WE_N}: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, LMR 0000. Every non-issue cycle drives NOP.
- Init pulses: PRECHARGE, REFRESH and LOAD_MODE set sticky pending flags. Each flag clears in the cycle its command issues, so a pulse arriving while BUSY is not lost.
- IDLE priority: pend_pre > pend_lmr > pend_ref > REF_REQ > READA > WRITEA.
  - While INIT_REQ=1, REF_REQ, READA and WRITEA are ignored.
- States: IDLE, PRE, REFR, LMR, ACT, RCD, COL, DONE.
- PRE: drive PRE with SA[10]=1, then T_RP-1 NOPs, then IDLE.
- REFR: drive REF, then T_RFC-1 NOPs, then IDLE.
  - When the source is REF_REQ, REF_ACK pulses 1 cycle coincident with the REF command.
  - Init refreshes do not pulse REF_ACK.
- LMR: drive LMR with SA=MODE_REG, BA=0, then T_MRD-1 NOPs, then IDLE.
- ACT: drive ACT with BA=bank, SA=row (both latched from SADDR at accept), then T_RCD-1 NOPs in RCD.
- COL: drive RD or WR with SA={A10=1, col zero-extended}; CM_ACK pulses 1 cycle with this command.
- Write:
  - OE=1 from the WR cycle for BURST cycles.
  - DONE waits BURST-1+T_WR+T_RP cycles, then IDLE.
- Read:
  - RD_VALID=1 for BURST cycles starting CL cycles after the RD cycle.
  - DONE waits CL+BURST-1+T_RP cycles, then IDLE.
- Minimum READA-to-IDLE with defaults: 1+2+1+(3+7+3)=17 cycles.
- Simultaneous events: READA and WRITEA both high → READA wins. A REF_REQ arriving during a burst is served at the next IDLE, ahead of any READA.
- Counters: a single 4-bit down-counter, sized for max(T_RFC, CL+BURST+T_RP); it saturates at 0.

Optional Feature:
- SDRAM_OUT_REG_EN defined: SA, BA, command pins, OE and RD_VALID pass through one extra output register (IOB packing).
  - Pin timing shifts +1 cycle.
  - REF_ACK and CM_ACK are unchanged.
  - Reset value of the extra register is deselect/0.
- Undefined: pins are driven directly from the FSM registers.

Decomposition:
- Shared package sdram_pkg:
  - pin command encoding constants (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_LMR)
  - state enum
  - address-field slice widths
- One natural sub-module: sdram_burst_timer, the load/decrement/zero-flag counter plus the OE/RD_VALID shift window.

Test Plan:
- PRECHARGE pulse in IDLE → PRE (0010, SA[10]=1) next cycle, BUSY for 3 cycles, no CM_ACK/REF_ACK.
- LOAD_MODE pulse arriving 1 cycle after a REFRESH pulse → REF issued, 6 NOPs, then LMR with SA=12'h033, BA=0; no pulse lost.
- READA with SADDR={2'd1,12'h0AB,8'h5C} → ACT BA=1 SA=0x0AB; RD 3 cycles later with SA=0x45C; CM_ACK with RD; RD_VALID high for 8 cycles starting 3 cycles after RD; IDLE 17 cycles after accept.
- WRITEA → WR with CM_ACK; OE high for 8 cycles from WR; next ACT no earlier than 12 cycles after WR.
- REF_REQ and READA both high in IDLE → REF with REF_ACK first, ACT exactly T_RFC=7 cycles later; with INIT_REQ=1 neither is served.
- RESET asserted mid read burst → next cycle pins 1111, RD_VALID=0, BUSY=0; a READA the following cycle starts cleanly with ACT.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command sequencer: pin command encodings,
// FSM state type, timer width and address-field defaults.
package sdram_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    localparam int CNT_W      = 4;
    localparam int A10_BIT    = 10;
    localparam int DEF_COL_W  = 8;
    localparam int DEF_ROW_W  = 12;
    localparam int DEF_BANK_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_REFR,
        ST_LMR,
        ST_ACT,
        ST_RCD,
        ST_COL,
        ST_DONE
    } state_t;

    // States that sit on the timer and return to dispatch when it reaches zero.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_PRE) || (s == ST_REFR) || (s == ST_LMR) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/sdram_burst_timer.sv
// Shared saturating down-counter for all FSM waits, plus the OE and RD_VALID
// burst windows launched by the WR/RD command cycles.
module sdram_burst_timer
    import sdram_pkg::*;
#(
    parameter int BURST = 8,
    parameter int CL    = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o,
    input  logic             wr_start_i,
    input  logic             rd_start_i,
    output logic             oe_o,
    output logic             rd_valid_o
);

    localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] oe_cnt_q, oe_cnt_d;
    logic [CNT_W-1:0] rv_cnt_q, rv_cnt_d;
    logic [CL-1:0]    rd_dly_q, rd_dly_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - ONE;
        if (load_i) begin
            cnt_d = load_val_i;
        end

        oe_cnt_d = (oe_cnt_q == '0) ? '0 : oe_cnt_q - ONE;
        if (wr_start_i) begin
            oe_cnt_d = BURST_LEN;
        end

        // rd_dly_q[0] is high during the RD cycle; the top tap marks CL-1 later.
        rd_dly_d = {rd_dly_q[CL-2:0], rd_start_i};
        rv_cnt_d = (rv_cnt_q == '0) ? '0 : rv_cnt_q - ONE;
        if (rd_dly_q[CL-1]) begin
            rv_cnt_d = BURST_LEN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            oe_cnt_q <= '0;
            rv_cnt_q <= '0;
            rd_dly_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            oe_cnt_q <= oe_cnt_d;
            rv_cnt_q <= rv_cnt_d;
            rd_dly_q <= rd_dly_d;
        end
    end

    assign zero_o     = (cnt_q == '0);
    assign oe_o       = (oe_cnt_q != '0);
    assign rd_valid_o = (rv_cnt_q != '0);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: init commands, hidden refresh and auto-precharge bursts.
// Define SDRAM_OUT_REG_EN to add one output register stage on SA/BA/cmd/OE/RD_VALID.
module sdram_cmd_sequencer
    import sdram_pkg::*;
#(
    parameter int              COL_W    = DEF_COL_W,
    parameter int              ROW_W    = DEF_ROW_W,
    parameter int              BANK_W   = DEF_BANK_W,
    parameter int              BURST    = 8,
    parameter int              CL       = 3,
    parameter int              T_RCD    = 3,
    parameter int              T_RP     = 3,
    parameter int              T_WR     = 2,
    parameter int              T_RFC    = 7,
    parameter int              T_MRD    = 2,
    parameter logic [ROW_W-1:0] MODE_REG = 12'h033
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            nop_i,
    input  logic                            reada_i,
    input  logic                            writea_i,
    input  logic                            refresh_i,
    input  logic                            precharge_i,
    input  logic                            load_mode_i,
    input  logic [BANK_W+ROW_W+COL_W-1:0]   saddr_i,
    input  logic                            ref_req_i,
    input  logic                            init_req_i,
    output logic                            ref_ack_o,
    output logic                            cm_ack_o,
    output logic [ROW_W-1:0]                sa_o,
    output logic [BANK_W-1:0]               ba_o,
    output logic                            cs_n_o,
    output logic                            ras_n_o,
    output logic                            cas_n_o,
    output logic                            we_n_o,
    output logic                            cke_o,
    output logic                            oe_o,
    output logic                            rd_valid_o,
    output logic                            busy_o
);

    localparam int ASIZE = BANK_W + ROW_W + COL_W;

    // Timer loads are total state occupancy minus one.
    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_RDONE = CNT_W'(CL + BURST - 1 + T_RP - 1);
    localparam logic [CNT_W-1:0] LD_WDONE = CNT_W'(BURST - 1 + T_WR + T_RP - 1);

    state_t              state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ROW_W-1:0]    sa_q, sa_d;
    logic [BANK_W-1:0]   ba_q, ba_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                is_rd_q, is_rd_d;
    logic                pend_pre_q, pend_pre_d;
    logic                pend_lmr_q, pend_lmr_d;
    logic                pend_ref_q, pend_ref_d;
    logic                ref_ack_q, ref_ack_d;
    logic                cm_ack_q, cm_ack_d;
    logic                busy_q, busy_d;

    logic                tmr_load, tmr_zero, wr_start, rd_start;
    logic [CNT_W-1:0]    tmr_val;
    logic                dispatch;
    logic [ROW_W-1:0]    col_sa, pre_sa;
    logic                fsm_oe, fsm_rd_valid;
    logic                unused_nop;

    assign unused_nop = nop_i;

    always_comb begin
        col_sa                = '0;
        col_sa[COL_W-1:0]     = col_q;
        col_sa[A10_BIT]       = 1'b1;
        pre_sa                = '0;
        pre_sa[A10_BIT]       = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = CMD_NOP;
        sa_d       = sa_q;
        ba_d       = ba_q;
        bank_d     = bank_q;
        row_d      = row_q;
        col_d      = col_q;
        is_rd_d    = is_rd_q;
        pend_pre_d = pend_pre_q | precharge_i;
        pend_lmr_d = pend_lmr_q | load_mode_i;
        pend_ref_d = pend_ref_q | refresh_i;
        ref_ack_d  = 1'b0;
        cm_ack_d   = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        wr_start   = 1'b0;
        rd_start   = 1'b0;
        dispatch   = 1'b0;

        unique case (state_q)
            ST_IDLE: dispatch = 1'b1;
            ST_ACT:  state_d  = ST_RCD;
            ST_RCD: begin
                if (tmr_zero) begin
                    state_d  = ST_COL;
                    cmd_d    = is_rd_q ? CMD_RD : CMD_WR;
                    sa_d     = col_sa;
                    ba_d     = bank_q;
                    cm_ack_d = 1'b1;
                    rd_start = is_rd_q;
                    wr_start = ~is_rd_q;
                end
            end
            ST_COL: begin
                state_d  = ST_DONE;
                tmr_load = 1'b1;
                tmr_val  = is_rd_q ? LD_RDONE : LD_WDONE;
            end
            default: dispatch = is_wait_state(state_q) && tmr_zero;
        endcase

        // Finishing a wait re-enters dispatch directly, so back-to-back
        // commands need no idle cycle between them.
        if (dispatch) begin
            state_d = ST_IDLE;
            if (pend_pre_d) begin
                state_d    = ST_PRE;
                cmd_d      = CMD_PRE;
                sa_d       = pre_sa;
                ba_d       = '0;
                pend_pre_d = 1'b0;
                tmr_load   = 1'b1;
                tmr_val    = LD_RP;
            end else if (pend_lmr_d) begin
                state_d    = ST_LMR;
                cmd_d      = CMD_LMR;
                sa_d       = MODE_REG;
                ba_d       = '0;
                pend_lmr_d = 1'b0;
                tmr_load   = 1'b1;
                tmr_val    = LD_MRD;
            end else if (pend_ref_d || (ref_req_i && !init_req_i)) begin
                state_d    = ST_REFR;
                cmd_d      = CMD_REF;
                ref_ack_d  = !pend_ref_d;
                pend_ref_d = 1'b0;
                tmr_load   = 1'b1;
                tmr_val    = LD_RFC;
            end else if ((reada_i || writea_i) && !init_req_i) begin
                state_d  = ST_ACT;
                cmd_d    = CMD_ACT;
                bank_d   = saddr_i[ASIZE-1 -: BANK_W];
                row_d    = saddr_i[COL_W +: ROW_W];
                col_d    = saddr_i[COL_W-1:0];
                is_rd_d  = reada_i;
                sa_d     = saddr_i[COL_W +: ROW_W];
                ba_d     = saddr_i[ASIZE-1 -: BANK_W];
                tmr_load = 1'b1;
                tmr_val  = LD_RCD;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_DESEL;
            sa_q       <= '0;
            ba_q       <= '0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            is_rd_q    <= 1'b0;
            pend_pre_q <= 1'b0;
            pend_lmr_q <= 1'b0;
            pend_ref_q <= 1'b0;
            ref_ack_q  <= 1'b0;
            cm_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            sa_q       <= sa_d;
            ba_q       <= ba_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            is_rd_q    <= is_rd_d;
            pend_pre_q <= pend_pre_d;
            pend_lmr_q <= pend_lmr_d;
            pend_ref_q <= pend_ref_d;
            ref_ack_q  <= ref_ack_d;
            cm_ack_q   <= cm_ack_d;
            busy_q     <= busy_d;
        end
    end

    sdram_burst_timer #(
        .BURST (BURST),
        .CL    (CL)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero),
        .wr_start_i (wr_start),
        .rd_start_i (rd_start),
        .oe_o       (fsm_oe),
        .rd_valid_o (fsm_rd_valid)
    );

    assign ref_ack_o = ref_ack_q;
    assign cm_ack_o  = cm_ack_q;
    assign busy_o    = busy_q;
    assign cke_o     = 1'b1;

`ifdef SDRAM_OUT_REG_EN
    logic [3:0]        cmd_p_q;
    logic [ROW_W-1:0]  sa_p_q;
    logic [BANK_W-1:0] ba_p_q;
    logic              oe_p_q, rd_valid_p_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_p_q      <= CMD_DESEL;
            sa_p_q       <= '0;
            ba_p_q       <= '0;
            oe_p_q       <= 1'b0;
            rd_valid_p_q <= 1'b0;
        end else begin
            cmd_p_q      <= cmd_q;
            sa_p_q       <= sa_q;
            ba_p_q       <= ba_q;
            oe_p_q       <= fsm_oe;
            rd_valid_p_q <= fsm_rd_valid;
        end
    end

    assign {cs_n_o, ras_n_o, cas_n_o, we_n_o} = cmd_p_q;
    assign sa_o       = sa_p_q;
    assign ba_o       = ba_p_q;
    assign oe_o       = oe_p_q;
    assign rd_valid_o = rd_valid_p_q;
`else
    assign {cs_n_o, ras_n_o, cas_n_o, we_n_o} = cmd_q;
    assign sa_o       = sa_q;
    assign ba_o       = ba_q;
    assign oe_o       = fsm_oe;
    assign rd_valid_o = fsm_rd_valid;
`endif

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Directed bench for sdram_cmd_sequencer: expected pin commands are queued
// when stimulus is driven and compared as the commands appear on the pins.
module tb_sdram_cmd_sequencer;

    localparam logic [3:0] P_NOP = 4'b0111;
    localparam logic [3:0] P_ACT = 4'b0011;
    localparam logic [3:0] P_RD  = 4'b0101;
    localparam logic [3:0] P_WR  = 4'b0100;
    localparam logic [3:0] P_PRE = 4'b0010;
    localparam logic [3:0] P_REF = 4'b0001;
    localparam logic [3:0] P_LMR = 4'b0000;
    localparam logic [3:0] P_DES = 4'b1111;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        nop_i = 1'b0, reada_i = 1'b0, writea_i = 1'b0;
    logic        refresh_i = 1'b0, precharge_i = 1'b0, load_mode_i = 1'b0;
    logic [21:0] saddr_i = '0;
    logic        ref_req_i = 1'b0, init_req_i = 1'b0;
    logic        ref_ack_o, cm_ack_o;
    logic [11:0] sa_o;
    logic [1:0]  ba_o;
    logic        cs_n_o, ras_n_o, cas_n_o, we_n_o, cke_o, oe_o, rd_valid_o, busy_o;

    sdram_cmd_sequencer dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .nop_i       (nop_i),
        .reada_i     (reada_i),
        .writea_i    (writea_i),
        .refresh_i   (refresh_i),
        .precharge_i (precharge_i),
        .load_mode_i (load_mode_i),
        .saddr_i     (saddr_i),
        .ref_req_i   (ref_req_i),
        .init_req_i  (init_req_i),
        .ref_ack_o   (ref_ack_o),
        .cm_ack_o    (cm_ack_o),
        .sa_o        (sa_o),
        .ba_o        (ba_o),
        .cs_n_o      (cs_n_o),
        .ras_n_o     (ras_n_o),
        .cas_n_o     (cas_n_o),
        .we_n_o      (we_n_o),
        .cke_o       (cke_o),
        .oe_o        (oe_o),
        .rd_valid_o  (rd_valid_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [11:0] sa;
        logic [11:0] sa_mask;
        logic        ba_chk;
        logic [1:0]  ba;
        logic        cm;
        logic        rf;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   rdv_lo = 1, rdv_hi = 0;
    int   oe_lo = 1, oe_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input int c, input logic [3:0] cmd, input logic [11:0] sa,
                        input logic [11:0] m, input logic bchk, input logic [1:0] ba,
                        input logic cm, input logic rf);
        exp_t e;
        e.cyc = c; e.cmd = cmd; e.sa = sa; e.sa_mask = m;
        e.ba_chk = bchk; e.ba = ba; e.cm = cm; e.rf = rf;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic wait_cm(input int budget);
        int i;
        i = 0;
        while (cm_ack_o !== 1'b1 && i < budget) begin
            tick(1);
            i++;
        end
        check("cm_ack_seen", {31'd0, cm_ack_o}, 32'd1);
    endtask

    // Pin monitor: windows every cycle, scoreboard pop on every real command.
    always @(negedge clk) begin
        logic [3:0] pins;
        exp_t       e;
        pins = {cs_n_o, ras_n_o, cas_n_o, we_n_o};
        check("rd_valid_window", {31'd0, rd_valid_o}, {31'd0, (cyc >= rdv_lo && cyc <= rdv_hi)});
        check("oe_window", {31'd0, oe_o}, {31'd0, (cyc >= oe_lo && cyc <= oe_hi)});
        if (pins !== P_NOP && pins !== P_DES) begin
            check("cmd_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cmd_cycle", cyc, e.cyc);
                check("cmd_pins", {28'd0, pins}, {28'd0, e.cmd});
                check("cmd_sa", {20'd0, sa_o & e.sa_mask}, {20'd0, e.sa & e.sa_mask});
                if (e.ba_chk) check("cmd_ba", {30'd0, ba_o}, {30'd0, e.ba});
                check("cmd_cm_ack", {31'd0, cm_ack_o}, {31'd0, e.cm});
                check("cmd_ref_ack", {31'd0, ref_ack_o}, {31'd0, e.rf});
            end
        end else begin
            check("idle_cm_ack", {31'd0, cm_ack_o}, 32'd0);
            check("idle_ref_ack", {31'd0, ref_ack_o}, 32'd0);
        end
    end

    initial begin
        int k;

        // Reset state
        tick(3);
        check("rst_pins", {28'd0, cs_n_o, ras_n_o, cas_n_o, we_n_o}, {28'd0, P_DES});
        check("rst_sa", {20'd0, sa_o}, 32'd0);
        check("rst_ba", {30'd0, ba_o}, 32'd0);
        check("rst_cke", {31'd0, cke_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        reset_i = 1'b0;
        tick(2);
        check("post_rst_pins", {28'd0, cs_n_o, ras_n_o, cas_n_o, we_n_o}, {28'd0, P_NOP});

        // PRECHARGE pulse in IDLE
        k = cyc;
        precharge_i = 1'b1;
        push(k + 1, P_PRE, 12'h400, 12'h400, 1'b0, 2'd0, 1'b0, 1'b0);
        tick(1);
        precharge_i = 1'b0;
        check("pre_busy_1", {31'd0, busy_o}, 32'd1);
        tick(2);
        check("pre_busy_3", {31'd0, busy_o}, 32'd1);
        tick(1);
        check("pre_busy_end", {31'd0, busy_o}, 32'd0);

        // REFRESH then LOAD_MODE one cycle later
        k = cyc;
        refresh_i = 1'b1;
        push(k + 1, P_REF, 12'h000, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0);
        tick(1);
        refresh_i = 1'b0;
        load_mode_i = 1'b1;
        push(k + 8, P_LMR, 12'h033, 12'hFFF, 1'b1, 2'd0, 1'b0, 1'b0);
        tick(1);
        load_mode_i = 1'b0;
        tick_to(k + 10);
        check("lmr_idle", {31'd0, busy_o}, 32'd0);

        // READA
        k = cyc;
        saddr_i = {2'd1, 12'h0AB, 8'h5C};
        reada_i = 1'b1;
        push(k + 1, P_ACT, 12'h0AB, 12'hFFF, 1'b1, 2'd1, 1'b0, 1'b0);
        push(k + 4, P_RD, 12'h45C, 12'hFFF, 1'b1, 2'd1, 1'b1, 1'b0);
        rdv_lo = k + 7; rdv_hi = k + 14;
        wait_cm(20);
        reada_i = 1'b0;
        tick_to(k + 17);
        check("rd_busy_last", {31'd0, busy_o}, 32'd1);
        tick(1);
        check("rd_idle", {31'd0, busy_o}, 32'd0);

        // WRITEA followed by a queued READA
        k = cyc;
        saddr_i = {2'd2, 12'h123, 8'hA7};
        writea_i = 1'b1;
        push(k + 1, P_ACT, 12'h123, 12'hFFF, 1'b1, 2'd2, 1'b0, 1'b0);
        push(k + 4, P_WR, 12'h4A7, 12'hFFF, 1'b1, 2'd2, 1'b1, 1'b0);
        oe_lo = k + 4; oe_hi = k + 11;
        wait_cm(20);
        writea_i = 1'b0;
        saddr_i = {2'd3, 12'h3FF, 8'h01};
        reada_i = 1'b1;
        push(k + 17, P_ACT, 12'h3FF, 12'hFFF, 1'b1, 2'd3, 1'b0, 1'b0);
        push(k + 20, P_RD, 12'h401, 12'hFFF, 1'b1, 2'd3, 1'b1, 1'b0);
        rdv_lo = k + 23; rdv_hi = k + 30;
        tick(1);
        wait_cm(30);
        reada_i = 1'b0;
        tick_to(k + 34);
        check("wr_rd_idle", {31'd0, busy_o}, 32'd0);

        // REF_REQ and READA together
        k = cyc;
        saddr_i = {2'd0, 12'h001, 8'h02};
        ref_req_i = 1'b1;
        reada_i = 1'b1;
        push(k + 1, P_REF, 12'h000, 12'h000, 1'b0, 2'd0, 1'b0, 1'b1);
        push(k + 8, P_ACT, 12'h001, 12'hFFF, 1'b1, 2'd0, 1'b0, 1'b0);
        push(k + 11, P_RD, 12'h402, 12'hFFF, 1'b1, 2'd0, 1'b1, 1'b0);
        rdv_lo = k + 14; rdv_hi = k + 21;
        tick(1);
        check("ref_ack_pulse", {31'd0, ref_ack_o}, 32'd1);
        ref_req_i = 1'b0;
        wait_cm(20);
        reada_i = 1'b0;
        tick_to(k + 25);
        check("ref_rd_idle", {31'd0, busy_o}, 32'd0);

        // INIT_REQ masks REF_REQ and READA
        init_req_i = 1'b1;
        ref_req_i = 1'b1;
        reada_i = 1'b1;
        tick(5);
        check("init_mask_busy", {31'd0, busy_o}, 32'd0);
        init_req_i = 1'b0;
        ref_req_i = 1'b0;
        reada_i = 1'b0;
        tick(2);

        // RESET in the middle of a read burst
        k = cyc;
        saddr_i = {2'd3, 12'h2F0, 8'h11};
        reada_i = 1'b1;
        push(k + 1, P_ACT, 12'h2F0, 12'hFFF, 1'b1, 2'd3, 1'b0, 1'b0);
        push(k + 4, P_RD, 12'h411, 12'hFFF, 1'b1, 2'd3, 1'b1, 1'b0);
        rdv_lo = k + 7; rdv_hi = k + 9;
        wait_cm(20);
        reada_i = 1'b0;
        tick_to(k + 9);
        reset_i = 1'b1;
        tick(1);
        check("midrst_pins", {28'd0, cs_n_o, ras_n_o, cas_n_o, we_n_o}, {28'd0, P_DES});
        check("midrst_rdv", {31'd0, rd_valid_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        reset_i = 1'b0;
        saddr_i = {2'd1, 12'h055, 8'h66};
        reada_i = 1'b1;
        push(k + 11, P_ACT, 12'h055, 12'hFFF, 1'b1, 2'd1, 1'b0, 1'b0);
        push(k + 14, P_RD, 12'h466, 12'hFFF, 1'b1, 2'd1, 1'b1, 1'b0);
        rdv_lo = k + 17; rdv_hi = k + 24;
        wait_cm(20);
        reada_i = 1'b0;
        tick_to(k + 28);
        check("post_rst_idle", {31'd0, busy_o}, 32'd0);

        tick(2);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
